// File: rtl/eight_to_three.sv
// Registered 8-to-3 priority encoder with a request-present flag.
// Latency: 1 cycle from sampling in to out/valid(/multi).
// Backpressure: none; a new sample is taken on every clock edge.
//
// Ports:
//   clk    - single clock, all state updates on the rising edge
//   rst_n  - asynchronous active-low reset, clears every output
//   in     - 8-bit request vector, bit i = request i
//   out    - registered index of the winning set bit
//   valid  - registered, 1 when the sampled vector had any bit set
//   multi  - registered, 1 when two or more bits were set
//            (present only when ENCODER_ONEHOT_CHECK_EN is defined)
//
// Parameter MSB_PRIORITY: 1 = highest set bit wins, 0 = lowest set bit wins.
// Optional feature macro: ENCODER_ONEHOT_CHECK_EN.

module eight_to_three #(
    parameter int MSB_PRIORITY = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in,
    output logic [2:0] out,
    output logic       valid
`ifdef ENCODER_ONEHOT_CHECK_EN
    ,
    output logic       multi
`endif
);

    logic [2:0] out_d;
    logic [2:0] out_q;
    logic       valid_d;
    logic       valid_q;

    // The loop direction decides priority: the last set bit visited wins,
    // so an ascending scan favours the MSB and a descending scan the LSB.
    always_comb begin
        out_d = 3'd0;
        if (MSB_PRIORITY != 0) begin
            for (int i = 0; i < 8; i++) begin
                if (in[i]) begin
                    out_d = 3'(i);
                end
            end
        end else begin
            for (int i = 7; i >= 0; i--) begin
                if (in[i]) begin
                    out_d = 3'(i);
                end
            end
        end
    end

    assign valid_d = |in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= 3'd0;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign out   = out_q;
    assign valid = valid_q;

`ifdef ENCODER_ONEHOT_CHECK_EN
    logic multi_d;
    logic multi_q;

    // Clearing the lowest set bit leaves something only if a second bit was set.
    assign multi_d = |(in & (in - 8'd1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            multi_q <= 1'b0;
        end else begin
            multi_q <= multi_d;
        end
    end

    assign multi = multi_q;
`endif

endmodule

// File: tb/tb_eight_to_three.sv
// Bench for eight_to_three: both priority settings instantiated side by side
// on the same request vector, checked through an expectation queue.

module tb_eight_to_three;

    logic       clk;
    logic       rst_n;
    logic [7:0] in;

    logic [2:0] out_m;
    logic       valid_m;
    logic [2:0] out_l;
    logic       valid_l;
    logic       multi_m;
    logic       multi_l;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct packed {
        logic [2:0] out_msb;
        logic [2:0] out_lsb;
        logic       valid;
        logic       multi;
    } exp_t;

    exp_t sb_q[$];

    eight_to_three #(.MSB_PRIORITY(1)) u_msb (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in),
        .out   (out_m),
        .valid (valid_m)
`ifdef ENCODER_ONEHOT_CHECK_EN
        ,
        .multi (multi_m)
`endif
    );

    eight_to_three #(.MSB_PRIORITY(0)) u_lsb (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in),
        .out   (out_l),
        .valid (valid_l)
`ifdef ENCODER_ONEHOT_CHECK_EN
        ,
        .multi (multi_l)
`endif
    );

`ifndef ENCODER_ONEHOT_CHECK_EN
    assign multi_m = 1'b0;
    assign multi_l = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: arithmetic on the integer value of the request vector.
    function automatic exp_t model(input logic [7:0] v);
        exp_t e;
        int   iv;
        iv = int'(v);
        e.valid   = (iv != 0);
        e.out_msb = (iv == 0) ? 3'd0 : 3'($clog2(iv + 1) - 1);
        e.out_lsb = (iv == 0) ? 3'd0 : 3'($clog2(iv & -iv));
`ifdef ENCODER_ONEHOT_CHECK_EN
        e.multi   = ($countones(v) >= 2);
`else
        e.multi   = 1'b0;
`endif
        return e;
    endfunction

    task automatic chk(input string name, input logic [4:0] got, input logic [4:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s in=%02h got {out,valid,multi}=%b expected %b", name, in, got, exp);
        end
    endtask

    task automatic drive(input logic [7:0] v);
        @(negedge clk);
        in = v;
        sb_q.push_back(model(v));
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && sb_q.size() > 0; k++) begin
            @(posedge clk);
        end
        @(posedge clk);
        #2;
        n_total++;
        if (sb_q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL drain pending=%0d expected 0", sb_q.size());
        end
    endtask

    // Monitor: one sample per edge, checked just after the edge.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("msb_enc", {out_m, valid_m, multi_m}, {e.out_msb, e.valid, e.multi});
            chk("lsb_enc", {out_l, valid_l, multi_l}, {e.out_lsb, e.valid, e.multi});
        end
    end

    initial begin
        logic [7:0] v;
        rst_n = 1'b1;
        in    = 8'h00;

        // Asynchronous reset with all requests set, before any clock edge.
        #1;
        rst_n = 1'b0;
        in    = 8'hFF;
        #1;
        chk("reset_async_msb", {out_m, valid_m, multi_m}, 5'b0);
        chk("reset_async_lsb", {out_l, valid_l, multi_l}, 5'b0);

        // Reset held across edges while in toggles.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in = 8'($urandom_range(1, 255));
            @(posedge clk);
            #1;
            chk("reset_hold_msb", {out_m, valid_m, multi_m}, 5'b0);
            chk("reset_hold_lsb", {out_l, valid_l, multi_l}, 5'b0);
        end

        // Release; first edge loads the vector present at that edge.
        @(negedge clk);
        rst_n = 1'b1;
        in    = 8'hFF;
        sb_q.push_back(model(8'hFF));

        // One-hot sweep.
        for (int i = 0; i < 8; i++) begin
            v = 8'h01 << i;
            drive(v);
        end

        // Multi-hot, zero, then the lowest single bit.
        drive(8'h9C);
        drive(8'h00);
        drive(8'h01);

        // Randomised mix of zero, one-hot and arbitrary vectors.
        for (int k = 0; k < 300; k++) begin
            case ($urandom_range(0, 3))
                0:       v = 8'h00;
                1:       v = 8'h01 << $urandom_range(0, 7);
                default: v = 8'($urandom_range(0, 255));
            endcase
            drive(v);
        end
        drain();

        // Mid-stream reset: pending sample discarded, first edge after release loads in.
        drive(8'hA5);
        drain();
        @(negedge clk);
        in = 8'h40;
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_mid_msb", {out_m, valid_m, multi_m}, 5'b0);
        chk("reset_mid_lsb", {out_l, valid_l, multi_l}, 5'b0);
        #1;
        rst_n = 1'b1;
        sb_q.push_back(model(8'h40));
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout pending=%0d", sb_q.size());
        $fatal(1, "timeout");
    end

endmodule
